// File: rtl/ci_pkg.sv
// Shared types and constants for the custom-instruction initiator.
// State encoding, bus widths and well-known responder ids.
package ci_pkg;

    localparam int CI_ID_WIDTH   = 8;
    localparam int CI_DATA_WIDTH = 32;

    localparam logic [CI_ID_WIDTH-1:0] CI_ID_RAM_DMA = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } ci_state_e;

    typedef struct packed {
        logic [CI_ID_WIDTH-1:0]   ci_n;
        logic [CI_DATA_WIDTH-1:0] value_a;
        logic [CI_DATA_WIDTH-1:0] value_b;
    } ci_req_t;

endpackage

// File: rtl/ci_timeout_counter.sv
// Saturating wait counter with a terminal-count flag.
// A zero TIMEOUT_CYCLES never raises the terminal flag.
module ci_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign terminal = 1'b0;
        end else begin : g_on
            assign terminal = (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/ci_initiator.sv
// Master side of the custom-instruction bus: one CI in flight,
// command in on valid/ready, result or timeout out on valid/ready.
module ci_initiator
    import ci_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [7:0]  cmdCiN,
    input  logic [31:0] cmdValueA,
    input  logic [31:0] cmdValueB,
    output logic        start,
    output logic [7:0]  ciN,
    output logic [31:0] valueA,
    output logic [31:0] valueB,
    input  logic        done,
    input  logic [31:0] result,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspResult,
    output logic        rspTimeout,
    output logic        spuriousDone
);

    ci_state_e state;
    ci_req_t   req;
    logic      tmo_hit;

    assign ciN    = req.ci_n;
    assign valueA = req.value_a;
    assign valueB = req.value_b;

    ci_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_tmo (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .terminal(tmo_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            req          <= '0;
            cmdReady     <= 1'b1;
            start        <= 1'b0;
            rspValid     <= 1'b0;
            rspResult    <= '0;
            rspTimeout   <= 1'b0;
            spuriousDone <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (done) spuriousDone <= 1'b1;
                    if (cmdValid) begin
                        req      <= '{cmdCiN, cmdValueA, cmdValueB};
                        start    <= 1'b1;
                        cmdReady <= 1'b0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start <= 1'b0;
                    if (done) begin
                        rspResult  <= result;
                        rspTimeout <= 1'b0;
                        rspValid   <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // done outranks a timeout landing in the same cycle
                    if (done) begin
                        rspResult  <= result;
                        rspTimeout <= 1'b0;
                        rspValid   <= 1'b1;
                        state      <= ST_RESP;
                    end else if (tmo_hit) begin
                        rspResult  <= '0;
                        rspTimeout <= 1'b1;
                        rspValid   <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (done) spuriousDone <= 1'b1;
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        cmdReady <= 1'b1;
                        req      <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ci_initiator.md
Name: ci_initiator

Overview:
- Master end of the custom-instruction (CI) interface: drives start/ciN/valueA/valueB and collects done/result from a CI responder such as the RAM-DMA custom instruction.
- Takes commands from a valid/ready command port, issues one CI at a time, and returns the result or a timeout on a valid/ready response port.
- Lets hardware sequencers and the testbench drive CI responders without the CPU.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT before abort; 0 disables the timeout (wait forever).
- CNT_WIDTH, 16: width of the timeout counter; TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmdValid  in  1  command present
- cmdReady  out  1  initiator accepts command this cycle
- cmdCiN  in  8  custom-instruction id
- cmdValueA  in  32  operand A
- cmdValueB  in  32  operand B
- start  out  1  CI start pulse to responder
- ciN  out  8  CI id to responder
- valueA  out  32  operand A to responder
- valueB  out  32  operand B to responder
- done  in  1  responder completion strobe
- result  in  32  responder result, valid only while done=1
- rspValid  out  1  response available
- rspReady  in  1  consumer takes response
- rspResult  out  32  captured result (0 on timeout)
- rspTimeout  out  1  response is a timeout abort
- spuriousDone  out  1  sticky: done seen while no CI outstanding

Behaviour:
- Reset values:
  - cmdReady=1 and state IDLE.
  - start=0, ciN=0, valueA=0, valueB=0.
  - rspValid=0, rspResult=0, rspTimeout=0, spuriousDone=0, counter=0.
- States:
  - IDLE: cmdReady=1. cmdValid at edge T latches ciN/valueA/valueB from cmd*, then goes to ISSUE.
  - ISSUE: start=1 for exactly this one cycle (T+1). If done=1 in this same cycle, capture result and go to RESP. Otherwise go to WAIT with counter=0.
  - WAIT: start=0.
    - done=1: capture result, rspTimeout=0, go to RESP.
    - Otherwise counter increments. When counter==TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES≠0, go to RESP with rspResult=0 and rspTimeout=1.
    - done and timeout in the same cycle: done wins.
  - RESP: rspValid=1; rspResult and rspTimeout are held stable. rspReady=1 goes to IDLE. cmdReady stays 0 in RESP, so there is no same-cycle new accept.
- ciN/valueA/valueB are driven from registers and held stable from ISSUE until the exit of WAIT. They return to 0 on entry to IDLE.
- Minimum latency:
  - cmd accepted at edge T, start high in cycle T+1.
  - Done in T+1 gives rspValid in T+2.
  - Done at cycle T+1+k gives rspValid at T+2+k.
- Only one CI is outstanding at a time. There is no internal command queue.
- done=1 in IDLE or RESP is ignored for data and sets spuriousDone (sticky until reset). This includes a late done after a timeout.
- cmdValid while not ready: command is not consumed; the source must hold it.
- Reset asserted in any state returns to reset values on the next edge. An in-flight CI is abandoned and its later done sets spuriousDone.
- Counter saturates and never wraps.

Decomposition:
- Shared package ci_pkg:
  - State encoding (IDLE, ISSUE, WAIT, RESP).
  - CI_ID_WIDTH=8 and CI_DATA_WIDTH=32.
  - The responder id constant for the RAM-DMA CI (8'h0F).
- One sub-module, ci_timeout_counter: clear/enable inputs, terminal-count output, TIMEOUT_CYCLES=0 handled inside.
- FSM and datapath registers stay in ci_initiator.

Test Plan:
- Combinational responder (done=1 in the start cycle, result=A+B): cmd ciN=0x0F, A=5, B=7 accepted at T → start only at T+1, rspValid at T+2, rspResult=12, rspTimeout=0.
- Multi-cycle responder (done 5 cycles after start): A=0x200, B=3 → valueA=0x200 held through WAIT, single start pulse, rspValid 6 cycles after start, result captured exactly in the done cycle.
- Timeout, TIMEOUT_CYCLES=8, responder never answers → rspValid with rspTimeout=1 and rspResult=0 after the WAIT count expires. A later done sets spuriousDone=1.
- Backpressure: rspReady=0 for 4 cycles → rspValid and rspResult stable, cmdReady=0, and a second cmdValid is not accepted. rspReady=1 → IDLE, then the second command issues.
- Back-to-back: 10 commands with incrementing A and B, rspReady=1 → 10 responses in order with correct results, and no overlap of start pulses.
- Reset mid-WAIT → all outputs at reset values the next cycle. The old done arriving after reset sets spuriousDone, and the next command completes normally.
